recip_arbiter: RTL and testbench
================================

Name: recip_arbiter

Overview:
- Shares one reciprocal unit (Q-format 1/x, start/done handshake, multi-cycle) among NREQ requesters in the watchdog datapath.
- Arbitrates round-robin and latches the winner's operand.
- Drives a single-cycle start, holds the operand stable until done, and returns the result tagged with the requester ID.
- Sits between the watchdog rate/period-computation clients and the reciprocal unit.

Parameters:
- W, 32: operand/result width. Q-format is opaque to this block; data passes through unmodified.
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: width of requester ID, equal to clog2(NREQ).
- TIMEOUT, 64: cycles from start pulse to forced abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request. Must be held with data stable until accepted.
- req_data  in  NREQ*W  operand, requester i at [i*W +: W], signed
- req_ready  out  NREQ  one-hot accept. Transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  single-cycle result strobe
- rsp_id  out  IDW  requester owning the result
- rsp_data  out  W  reciprocal result
- rsp_invalid  out  1  unit flagged operand <= 0
- busy  out  1  high whenever state != IDLE
- ru_start  out  1  single-cycle start pulse to the unit
- ru_x  out  W  operand to the unit. Held constant from start until the cycle after ru_done.
- ru_done  in  1  unit completion strobe
- ru_x_inv  in  W  unit result, valid while ru_done is high
- ru_invalid  in  1  unit invalid flag, valid while ru_done is high

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 has first priority; ru_x register 0.
- States:
  - IDLE: accept a request when one is pending, else stay.
  - START: go to WAIT.
  - WAIT: go to RESP when ru_done is high.
  - RESP: go to IDLE.
- req_ready is combinational and nonzero only in IDLE.
  - It selects the first asserted req_valid searching from pointer+1 upward, with wrap-around.
  - At most one bit is set. It is 0 if no request is pending.
- Accept cycle T, in IDLE:
  - latch req_data[sel] into ru_x and sel into the ID register;
  - pointer <= sel;
  - next state START.
- Cycle T+1 (START): ru_start = 1 for exactly this cycle.
- WAIT: hold ru_x. The cycle in which ru_done is seen, latch ru_x_inv and ru_invalid.
- RESP: rsp_valid = 1 for one cycle, with rsp_id, rsp_data and rsp_invalid from the latches. These hold their values afterward until the next RESP.
- Latency: rsp_valid occurs at unit latency + 2 cycles after the accept cycle. Earliest next accept is the cycle after RESP.
- A requester that drops req_valid before acceptance is simply not served; no error.
- A single requester asserting continuously is served back-to-back. Pointer fairness guarantees that any other pending requester is served within NREQ grants.
- ru_done outside WAIT is ignored: no response, no state change.
- No response back-pressure: the consumer must accept rsp_valid in the cycle it is asserted.
- Asynchronous reset mid-transaction returns to IDLE at once; the in-flight request is lost without a response. The unit shares rst_n.

Optional Feature:
- Macro RECIP_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, cleared at START.
  - If TIMEOUT cycles elapse without ru_done, go to RESP with rsp_data = 0, rsp_invalid = 1 and an additional output rsp_timeout = 1. rsp_timeout is 0 on normal responses.
  - A late ru_done after the abort is ignored, per the rule above.
  - If ru_done and expiry coincide, ru_done wins.
- Undefined: no counter, no rsp_timeout port; WAIT waits indefinitely.

Test Plan:
- Stub unit with fixed 9-cycle done latency returning ~x. Requester 2 sends 0x0002_0000.
  - ru_start occurs 1 cycle after accept; ru_x = 0x0002_0000 is stable through done.
  - rsp_valid occurs 11 cycles after accept with rsp_id=2, rsp_data=0xFFFD_FFFF, rsp_invalid=0.
- All 4 requesters held valid from reset -> grant order 0,1,2,3,0. Exactly one req_ready bit per grant; no grant while busy=1.
- Stub asserts ru_invalid for operand 0xFFFF_0000 (negative) -> rsp_invalid=1, correct rsp_id, no hang.
- Spurious ru_done pulse in IDLE -> no rsp_valid, state stays IDLE, pointer unchanged.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. A new request is then granted to requester 0 first, and the old transaction never responds.
- With RECIP_ARB_TIMEOUT_EN, TIMEOUT=16, and a stub that never asserts done -> rsp_valid with rsp_timeout=1, rsp_invalid=1, rsp_data=0 exactly 17 cycles after ru_start. The next request is then served normally.

Source files
------------

// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin front end for one shared multi-cycle reciprocal
// unit. Latches the winning requester's operand, issues a one-cycle start,
// holds the operand until done, and returns the result tagged with the
// requester ID.
// Optional build macro RECIP_ARB_TIMEOUT_EN: adds a WAIT watchdog that aborts
// after TIMEOUT cycles and reports the abort on rsp_timeout.
module recip_arbiter #(
    parameter int W    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
`ifdef RECIP_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_invalid,
`ifdef RECIP_ARB_TIMEOUT_EN
    output logic              rsp_timeout,
`endif
    output logic              busy,
    output logic              ru_start,
    output logic [W-1:0]      ru_x,
    input  logic              ru_done,
    input  logic [W-1:0]      ru_x_inv,
    input  logic              ru_invalid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [W-1:0]     x_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [W-1:0]     rsp_data_reg;
    logic             rsp_inv_reg;
    logic             grant_found;
    logic [IDW-1:0]   sel_id;
    logic [W-1:0]     sel_data;
    logic             accept;
    logic             expire;

    // Round-robin search starting just after the last winner, with wrap.
    always_comb begin
        grant_found = 1'b0;
        sel_id      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[(int'(ptr_reg) + k) % NREQ]) begin
                grant_found = 1'b1;
                sel_id      = IDW'((int'(ptr_reg) + k) % NREQ);
            end
        end
    end

    assign sel_data = req_data[int'(sel_id)*W +: W];
    assign accept   = (state_reg == IDLE) && grant_found;

    // One-hot accept, only offered while idle and out of reset.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && accept && (sel_id == IDW'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        ru_start   = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (grant_found) state_next = START;
            end
            START: begin
                ru_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A completing unit takes priority over a coincident expiry.
                if (ru_done || expire) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's operand and ID; the pointer follows the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= IDW'(NREQ - 1);
            id_reg  <= '0;
            x_reg   <= '0;
        end else if (accept) begin
            ptr_reg <= sel_id;
            id_reg  <= sel_id;
            x_reg   <= sel_data;
        end
    end

    // Response latches load when WAIT ends and hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_inv_reg  <= 1'b0;
        end else if (state_reg == WAIT) begin
            if (ru_done) begin
                rsp_id_reg   <= id_reg;
                rsp_data_reg <= ru_x_inv;
                rsp_inv_reg  <= ru_invalid;
            end else if (expire) begin
                rsp_id_reg   <= id_reg;
                rsp_data_reg <= '0;
                rsp_inv_reg  <= 1'b1;
            end
        end
    end

`ifdef RECIP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_reg;
    logic          timeout_reg;

    // Counts cycles spent in WAIT; restarted by each start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wait_cnt_reg <= '0;
        else if (state_reg == START)  wait_cnt_reg <= '0;
        else if (state_reg == WAIT)   wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end

    assign expire = (state_reg == WAIT) && (wait_cnt_reg == CW'(TIMEOUT - 1));

    // Abort flag accompanies the response it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
        end else if (state_reg == WAIT) begin
            if (ru_done)     timeout_reg <= 1'b0;
            else if (expire) timeout_reg <= 1'b1;
        end
    end

    assign rsp_timeout = timeout_reg;
`else
    assign expire = 1'b0;
`endif

    assign rsp_id      = rsp_id_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_invalid = rsp_inv_reg;
    assign ru_x        = x_reg;

endmodule

// File: tb/tb_recip_arbiter.sv
// Testbench for recip_arbiter: stub reciprocal unit (9-cycle done, returns ~x,
// flags x <= 0), cycle-level reference model and response scoreboard.
// Build with RECIP_ARB_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_recip_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_invalid;
    logic              busy;
    logic              ru_start;
    logic [W-1:0]      ru_x;
    logic              ru_done;
    logic [W-1:0]      ru_x_inv;
    logic              ru_invalid;
`ifdef RECIP_ARB_TIMEOUT_EN
    logic              rsp_timeout;
`endif

    recip_arbiter #(
        .W(W),
        .NREQ(NREQ),
        .IDW(IDW)
`ifdef RECIP_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_invalid(rsp_invalid),
`ifdef RECIP_ARB_TIMEOUT_EN
        .rsp_timeout(rsp_timeout),
`endif
        .busy(busy),
        .ru_start(ru_start),
        .ru_x(ru_x),
        .ru_done(ru_done),
        .ru_x_inv(ru_x_inv),
        .ru_invalid(ru_invalid)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       inv;
        logic       tmo;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // reference model state
    logic         m_idle = 1'b1;
    int           m_ptr = NREQ - 1;
    int           m_start = -1;
    int           m_resp = -1;
    logic [W-1:0] m_x = '0;
    int           last_id = 0;
    logic [W-1:0] last_data = '0;
    logic         last_inv = 1'b0;

    // stub controls
    logic never_done = 1'b0;
    logic spur_req = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stub reciprocal unit: done 9 cycles after the start pulse.
    initial begin
        logic         pend;
        int           cnt;
        logic [W-1:0] sx;
        pend = 1'b0; cnt = 0; sx = '0;
        ru_done = 1'b0; ru_x_inv = '0; ru_invalid = 1'b0;
        forever begin
            @(negedge clk);
            ru_done    = 1'b0;
            ru_invalid = 1'b0;
            ru_x_inv   = W'($urandom);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (spur_req) begin
                    ru_done  = 1'b1;
                    spur_req = 1'b0;
                end
                if (ru_start && !never_done) begin
                    pend = 1'b1; cnt = 0; sx = ru_x;
                end else if (pend) begin
                    cnt++;
                    if (cnt == 9) begin
                        ru_done    = 1'b1;
                        ru_x_inv   = ~sx;
                        ru_invalid = ($signed(sx) <= 0);
                        pend       = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check_val("rst_busy", busy, 0);
                check_val("rst_ru_start", ru_start, 0);
                check_val("rst_rsp_valid", rsp_valid, 0);
                check_val("rst_rsp_id", rsp_id, 0);
                check_val("rst_rsp_data", rsp_data, 0);
                check_val("rst_rsp_invalid", rsp_invalid, 0);
                check_val("rst_ru_x", ru_x, 0);
                check_val("rst_req_ready", req_ready, 0);
                sb.delete();
                m_idle = 1'b1; m_ptr = NREQ - 1;
                last_id = 0; last_data = '0; last_inv = 1'b0;
            end else if (m_idle) begin
                logic [NREQ-1:0] exp_ready;
                int sel;
                exp_ready = '0;
                sel = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (sel < 0 && req_valid[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
                if (sel >= 0) exp_ready[sel] = 1'b1;
                check_val("req_ready", req_ready, exp_ready);
                check_val("idle_busy", busy, 0);
                check_val("idle_rsp_valid", rsp_valid, 0);
                check_val("idle_ru_start", ru_start, 0);
                check_val("hold_rsp_data", rsp_data, last_data);
                check_val("hold_rsp_id", rsp_id, last_id);
                if (sel >= 0) begin
                    exp_t e;
                    int gidx;
                    logic [W-1:0] x;
                    x = req_data[sel*W +: W];
                    e.id = sel;
                    if (never_done) begin
                        e.data = '0; e.inv = 1'b1; e.tmo = 1'b1; e.cyc = cyc + 18;
                    end else begin
                        e.data = ~x; e.inv = ($signed(x) <= 0); e.tmo = 1'b0; e.cyc = cyc + 11;
                    end
                    sb.push_back(e);
                    m_ptr = sel; m_idle = 1'b0; m_start = cyc + 1; m_resp = e.cyc; m_x = x;
                    gidx = -1;
                    for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
                    grant_log.push_back(gidx);
                end
            end else begin
                check_val("busy_req_ready", req_ready, 0);
                check_val("busy_busy", busy, 1);
                check_val("ru_start", ru_start, (cyc == m_start));
                check_val("ru_x_stable", ru_x, m_x);
                if (cyc == m_resp) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("rsp_valid", rsp_valid, 1);
                    check_val("rsp_id", rsp_id, e.id);
                    check_val("rsp_data", rsp_data, e.data);
                    check_val("rsp_invalid", rsp_invalid, e.inv);
`ifdef RECIP_ARB_TIMEOUT_EN
                    check_val("rsp_timeout", rsp_timeout, e.tmo);
`endif
                    $display("rsp cycle=%0d id=%0d data=%h invalid=%0d", cyc, rsp_id, rsp_data, rsp_invalid);
                    last_id = e.id; last_data = e.data; last_inv = e.inv;
                    m_idle = 1'b1;
                end else begin
                    check_val("busy_rsp_valid", rsp_valid, 0);
                    check_val("hold_rsp_data", rsp_data, last_data);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_idle && sb.size() == 0) break;
        end
    endtask

    task automatic send(input int id, input logic [W-1:0] d);
        logic seen;
        seen = 1'b0;
        req_data[id*W +: W] = d;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check_val("send_granted", seen, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_idle();
    endtask

    task automatic run_set(input logic [NREQ-1:0] mask, input int n);
        logic [NREQ-1:0] g;
        int got;
        got = 0;
        req_valid = req_valid | mask;
        for (int i = 0; i < 400 && got < n; i++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            if (g != '0) begin
                got++;
                @(posedge clk); #1;
                req_valid = req_valid & ~g;
            end
        end
        req_valid = req_valid & ~mask;
        check_val("run_set_grants", got, n);
        wait_idle();
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1;

        // all requesters valid from reset: grant order 0,1,2,3,0
        req_data[0*W +: W] = 32'h0000_1000;
        req_data[1*W +: W] = 32'h0100_0000;
        req_data[2*W +: W] = 32'h0002_0000;
        req_data[3*W +: W] = 32'h7FFF_FFFF;
        req_valid = '1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete();
        for (int n = 0; n < 200 && grant_log.size() < 5; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++)
            check_val("grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);

        // single request from requester 2, positive operand
        send(2, 32'h0002_0000);
        check_val("t1_rsp_id", rsp_id, 2);
        check_val("t1_rsp_data", rsp_data, 32'hFFFD_FFFF);
        check_val("t1_rsp_invalid", rsp_invalid, 0);

        // negative and zero operands are flagged invalid
        send(1, 32'hFFFF_0000);
        check_val("neg_rsp_invalid", rsp_invalid, 1);
        check_val("neg_rsp_id", rsp_id, 1);
        send(3, 32'h0000_0000);
        check_val("zero_rsp_invalid", rsp_invalid, 1);
        check_val("zero_rsp_data", rsp_data, 32'hFFFF_FFFF);

        // spurious done while idle; pointer stays at 3 so 0 wins before 3
        @(posedge clk); #1;
        spur_req = 1'b1;
        repeat (5) @(posedge clk); #1;
        grant_log.delete();
        run_set(4'b1001, 2);
        check_val("spur_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        check_val("spur_second_grant", (grant_log.size() > 1) ? grant_log[1] : -1, 3);

        // asynchronous reset in WAIT
        req_data[2*W +: W] = 32'h0000_8000;
        req_valid[2] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[2]) break;
        end
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_ru_x", ru_x, 0);
        check_val("arst_rsp_data", rsp_data, 0);
        check_val("arst_rsp_id", rsp_id, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete();
        run_set(4'b1011, 3);
        check_val("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

`ifdef RECIP_ARB_TIMEOUT_EN
        // unit never completes: watchdog aborts, then normal service resumes
        never_done = 1'b1;
        send(1, 32'h0000_4000);
        never_done = 1'b0;
        check_val("to_rsp_timeout", rsp_timeout, 1);
        check_val("to_rsp_data", rsp_data, 0);
        check_val("to_rsp_invalid", rsp_invalid, 1);
        send(2, 32'h0002_0000);
        check_val("after_to_timeout", rsp_timeout, 0);
        check_val("after_to_data", rsp_data, 32'hFFFD_FFFF);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
